// File: rtl/caliptra_prim_clock_div_step.sv
`default_nettype none
// ============================================================================
// Module   : caliptra_prim_clock_div_step
// Purpose  : Even-ratio clock divider with a step-down request/ack handshake.
//            Divides clk_i by DIVISOR, or by DIVISOR/2 while step-down is
//            acknowledged. The ratio changes only on the divided-clock rising
//            edge, so no runt pulse is produced. A one-cycle enable pulse marks
//            each divided-clock rising edge. In scan mode clk_o follows clk_i.
//
// Ports    : clk_i            in   source clock
//            rst_i            in   synchronous active-high reset
//            scanmode_i       in   scan-mode bypass select
//            step_down_req_i  in   level request, 1 = divide by DIVISOR/2
//            step_down_ack_o  out  1 while the DIVISOR/2 ratio is in effect
//            clk_en_o         out  one-cycle pulse on each divided rising edge
//            clk_o            out  divided clock (clk_i in scan bypass)
//
// Revision : 1.0  initial release
// ============================================================================
module caliptra_prim_clock_div_step #(
    parameter int   DIVISOR       = 4,
    parameter logic HAS_SCAN_MODE = 1'b1,
    parameter logic NO_FPGA_BUFG  = 1'b0
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic scanmode_i,
    input  wire logic step_down_req_i,
    output logic      step_down_ack_o,
    output logic      clk_en_o,
    output logic      clk_o
);

    localparam int CNT_W = $clog2(DIVISOR / 2);

    // Terminal counts (half - 1) for each ratio.
    localparam logic [CNT_W-1:0] c_LAST_NORMAL  = CNT_W'(DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0] c_LAST_STEPPED = CNT_W'(DIVISOR / 4 - 1);

    generate
        if ((DIVISOR < 4) || ((DIVISOR % 4) != 0)) begin : g_bad_divisor
            $error("DIVISOR must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_NORMAL  = 1'b0,
        ST_STEPPED = 1'b1
    } state_e;

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clk_q;
    logic             r_ack;
    logic             r_clk_en;

    logic             w_last;
    logic             w_boundary;
    logic             w_scan;

    assign w_last     = (r_cnt == ((r_state == ST_STEPPED) ? c_LAST_STEPPED : c_LAST_NORMAL));
    // The cycle on whose closing edge clk_q rises: the only point where the
    // ratio may change, so every phase keeps its full length.
    assign w_boundary = w_last && !r_clk_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_clk_q  <= 1'b0;
            r_state  <= ST_NORMAL;
            r_ack    <= 1'b0;
            r_clk_en <= 1'b0;
        end else begin
            if (w_last) begin
                r_cnt   <= '0;
                r_clk_q <= ~r_clk_q;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end

            r_clk_en <= w_boundary;

            // Request is only looked at on the boundary; the new half takes
            // effect with the period that opens on this same edge.
            if (w_boundary) begin
                case (r_state)
                    ST_NORMAL: begin
                        if (step_down_req_i) begin
                            r_state <= ST_STEPPED;
                            r_ack   <= 1'b1;
                        end
                    end
                    ST_STEPPED: begin
                        if (!step_down_req_i) begin
                            r_state <= ST_NORMAL;
                            r_ack   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_NORMAL;
                        r_ack   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign step_down_ack_o = r_ack;
    assign clk_en_o        = r_clk_en;

    assign w_scan = HAS_SCAN_MODE && scanmode_i;

    // Output clock mux. In this generic implementation both flavours reduce to
    // the same 2:1 select; technology builds swap in a buffered FPGA primitive.
    generate
        if (NO_FPGA_BUFG) begin : g_mux_nobufg
            assign clk_o = w_scan ? clk_i : r_clk_q;
        end else begin : g_mux_generic
            assign clk_o = w_scan ? clk_i : r_clk_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_caliptra_prim_clock_div_step.sv
`default_nettype none
// ============================================================================
// Module   : tb_caliptra_prim_clock_div_step
// Purpose  : Self-checking bench for caliptra_prim_clock_div_step. Two
//            instances (DIVISOR 4 and 8) share stimulus; a period-level model
//            predicts clk_o, clk_en_o and step_down_ack_o every cycle, and
//            directed literal checks pin the model at key points.
// Revision : 1.0  initial release
// ============================================================================
module tb_caliptra_prim_clock_div_step;

    logic       clk;
    logic       rst;
    logic       scan;
    logic       req;
    logic [1:0] en;
    logic [1:0] ack;
    logic [1:0] clko;

    int n_chk = 0;
    int n_err = 0;

    // Model: position within the divided period, measured from its rising
    // edge; the first half of each period is high.
    int m_div   [2] = '{4, 8};
    int m_pos   [2];
    int m_ratio [2];
    bit m_ack   [2];
    int en_cnt  [2];

    caliptra_prim_clock_div_step #(
        .DIVISOR       (4),
        .HAS_SCAN_MODE (1'b1),
        .NO_FPGA_BUFG  (1'b0)
    ) u_dut4 (
        .clk_i           (clk),
        .rst_i           (rst),
        .scanmode_i      (scan),
        .step_down_req_i (req),
        .step_down_ack_o (ack[0]),
        .clk_en_o        (en[0]),
        .clk_o           (clko[0])
    );

    caliptra_prim_clock_div_step #(
        .DIVISOR       (8),
        .HAS_SCAN_MODE (1'b1),
        .NO_FPGA_BUFG  (1'b0)
    ) u_dut8 (
        .clk_i           (clk),
        .rst_i           (rst),
        .scanmode_i      (scan),
        .step_down_req_i (req),
        .step_down_ack_o (ack[1]),
        .clk_en_o        (en[1]),
        .clk_o           (clko[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int actual, input int expected);
        n_chk++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    function automatic bit model_q(input int i);
        return m_pos[i] < (m_ratio[i] / 2);
    endfunction

    // Reset leaves the divider at the start of its low half.
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_pos[i]   = m_div[i] / 2;
            m_ratio[i] = m_div[i];
            m_ack[i]   = 1'b0;
            en_cnt[i]  = 0;
        end
    end

    // Model update on each rising edge, then compare just after it.
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    m_pos[i]   = m_div[i] / 2;
                    m_ratio[i] = m_div[i];
                    m_ack[i]   = 1'b0;
                end else begin
                    m_pos[i]++;
                    if (m_pos[i] == m_ratio[i]) begin
                        m_pos[i]   = 0;
                        m_ratio[i] = req ? m_div[i] / 2 : m_div[i];
                        m_ack[i]   = req;
                    end
                end
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("en%0d", m_div[i]), int'(en[i]),
                    (!rst && m_pos[i] == 0) ? 1 : 0);
                chk($sformatf("ack%0d", m_div[i]), int'(ack[i]), int'(m_ack[i]));
                chk($sformatf("clko_hi%0d", m_div[i]), int'(clko[i]),
                    scan ? 1 : int'(model_q(i)));
                if (en[i] === 1'b1) en_cnt[i]++;
            end
        end
    end

    // Low-phase check of clk_o (catches a bypass that is stuck or inverted).
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!$isunknown(clko)) begin
                for (int i = 0; i < 2; i++) begin
                    chk($sformatf("clko_lo%0d", m_div[i]), int'(clko[i]),
                        scan ? 0 : int'(model_q(i)));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    int c0;
    int c1;

    initial begin
        rst  = 1'b1;
        req  = 1'b0;
        scan = 1'b0;
        step(3);
        chk("rst_ack8", int'(ack[1]), 0);
        chk("rst_clko8", int'(clko[1]), 0);

        // 1: release; div4 pulses at cycles 2,6,10,14; div8 at 4,12.
        rst = 1'b0;
        c0 = en_cnt[0];
        c1 = en_cnt[1];
        step(2);
        chk("lit_first_en4", int'(en[0]), 1);
        step(14);
        chk("lit_en4_count", en_cnt[0] - c0, 4);
        chk("lit_en8_count", en_cnt[1] - c1, 2);

        // 2: div8 is at pos 4; move to mid-high (pos 2) and request.
        step(6);
        chk("lit_mid_high8", int'(clko[1]), 1);
        req = 1'b1;
        step(5);
        chk("lit_ack8_pre", int'(ack[1]), 0);
        step(1);
        chk("lit_ack8_rise", int'(ack[1]), 1);
        c1 = en_cnt[1];
        step(8);
        chk("lit_stepped_periods8", en_cnt[1] - c1, 2);

        // 3: drop request; ack falls at the next boundary 4 cycles on.
        req = 1'b0;
        step(3);
        chk("lit_ack8_hold", int'(ack[1]), 1);
        step(1);
        chk("lit_ack8_fall", int'(ack[1]), 0);
        c1 = en_cnt[1];
        step(16);
        chk("lit_normal_periods8", en_cnt[1] - c1, 2);

        // 4: one-cycle pulse between boundaries is lost.
        step(2);
        req = 1'b1;
        step(1);
        req = 1'b0;
        step(14);
        chk("lit_pulse_ack8", int'(ack[1]), 0);

        // 5: scan bypass; enables keep running.
        scan = 1'b1;
        c1 = en_cnt[1];
        step(16);
        chk("lit_scan_en8", en_cnt[1] - c1, 2);
        scan = 1'b0;
        step(8);

        // 6: reset in the middle of a stepped period.
        req = 1'b1;
        step(12);
        chk("lit_pre_rst_ack8", int'(ack[1]), 1);
        step(1);
        rst = 1'b1;
        step(1);
        chk("lit_rst_ack8", int'(ack[1]), 0);
        chk("lit_rst_en8", int'(en[1]), 0);
        chk("lit_rst_clko8", int'(clko[1]), 0);
        rst = 1'b0;
        step(3);
        chk("lit_ack8_wait", int'(ack[1]), 0);
        step(1);
        chk("lit_ack8_return", int'(ack[1]), 1);
        step(8);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
